risc_core_mc: RTL and testbench
===============================

// Module: risc_core_mc
// PURPOSE
//  Parametrised multi-cycle RISC core: next generation of the 8-bit single-cycle processor.
//  Fetch/decode/execute FSM with req/ack handshakes to external instruction and data memories,
//  memory-mapped I/O, hardwired-zero R0, conditional branch and HALT. Top-level CPU of the SoC.
// PARAMETERS
//  DATA_W    8      datapath, register and data-address width (>=8)
//  PC_W      8      program-counter / instruction-address width (>=8)
//  RESET_PC  0      PC value loaded on reset
//  IO_ADDR   'hFF   data address decoded as I/O port, not data memory
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high
//  imem_req     out  1       instruction fetch request
//  imem_addr    out  PC_W    fetch address (= PC)
//  imem_rdata   in   16      instruction word
//  imem_ack     in   1       fetch complete, rdata valid this cycle
//  dmem_req     out  1       data access request
//  dmem_we      out  1       1 = store, 0 = load
//  dmem_addr    out  DATA_W  effective address
//  dmem_wdata   out  DATA_W  store data
//  dmem_rdata   in   DATA_W  load data
//  dmem_ack     in   1       data access complete
//  io_in        in   DATA_W  external input, read by LOAD from IO_ADDR
//  io_out       out  DATA_W  external output register
//  io_out_valid out  1       1-cycle pulse when io_out written
//  halted       out  1       core stopped in HALT
//  illegal_op   out  1       sticky: undefined opcode decoded
// BEHAVIOUR
//  Encoding: [15:12] op, [11:10] rd, [9:8] rs1, [7:6] rs2, [7:0] imm8 (zero-extended to DATA_W).
//  Ops: 0 ADD rd=rs1+rs2; 1 SUB rd=rs1-rs2; 2 AND; 3 OR; 4 LI rd=imm8; 5 LOAD rd=M[rs1+imm8];
//   6 STORE M[rs1+imm8]=rd; 7 JUMP pc=imm8; 8 BEQ if rd==rs1 pc=imm8; 15 HALT; others NOP+illegal_op.
//  Arithmetic mod 2^DATA_W, no flags. PC+1 and targets mod 2^PC_W (imm8 zero-extended/truncated).
//  R0 reads 0 always; writes to R0 discarded.
//  Reset: state=FETCH, pc=RESET_PC, R0..R3=0, io_out=0; all outputs 0 except imem_addr=RESET_PC.
//  FSM FETCH->DECODE->EXEC->(MEM)->FETCH; HALT absorbing until reset.
//   FETCH:  imem_req=1 held until edge with imem_ack=1; then latch instr, go DECODE.
//   DECODE: read rs1/rs2/rd operands into latches.
//   EXEC:   ALU/LI write rd; JUMP/taken BEQ load target, else pc+1; LOAD/STORE -> MEM;
//           HALT -> HALT (pc not advanced, halted=1 from next cycle).
//   MEM:    addr==IO_ADDR: no dmem_req; LOAD writes io_in; STORE writes io_out, io_out_valid=1
//           for that edge's following cycle; 1 cycle. Else dmem_req=1 (dmem_we per op), addr/wdata
//           stable until edge with dmem_ack=1; LOAD writes dmem_rdata. Then pc+1, go FETCH.
//  Latency, zero-wait memory: ALU/LI/JUMP/BEQ 3 cycles, LOAD/STORE 4; each ack-wait cycle adds 1.
//  Ack while req=0 ignored. Requests never withdrawn before ack except by reset.
//  Reset mid-access: req drops immediately (async); memories must tolerate abandoned request.
//  io_out_valid and dmem_req never both high.
// STRUCTURE
//  Package risc_pkg: opcode localparams, FSM state encoding, instruction field bit positions.
//  Sub-module risc_core_regfile: 4 x DATA_W, 3 async read ports (rs1, rs2, rd), 1 sync write,
//  R0 hardwired 0, async reset to 0. FSM, PC, ALU and memory sequencing in risc_core_mc.
// TESTING
//  1 Reset mid-fetch (imem_ack low) -> imem_req drops same cycle; after release pc=00, regs 0.
//  2 LI R1,0xA5; LI R2,0x5A; ADD R3,R1,R2 -> R3=FF; SUB R3,R2,R1 -> R3=B5 (wrap); each 3 cycles.
//  3 STORE R1,0x20(R0) with 2 ack-wait cycles -> req/addr=20/wdata=A5 stable 3 cycles; LOAD back=A5.
//  4 io_in=F0, LOAD R2,0xFF(R0) -> R2=F0, no dmem_req; STORE R1,0xFF(R0) -> io_out=A5, 1-cycle pulse.
//  5 BEQ R1,R1,0x10 -> pc=10; BEQ R1,R0,0x30 -> pc=11; JUMP 0x05 -> pc=05; write R0 -> R0 stays 0.
//  6 Opcode 0xB -> illegal_op=1, pc+1; HALT -> halted=1, no further imem_req until reset.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the multi-cycle RISC core: opcodes, instruction field
// positions and the sequencing FSM state type.
package risc_pkg;

    localparam logic [3:0] OpAdd   = 4'h0;
    localparam logic [3:0] OpSub   = 4'h1;
    localparam logic [3:0] OpAnd   = 4'h2;
    localparam logic [3:0] OpOr    = 4'h3;
    localparam logic [3:0] OpLi    = 4'h4;
    localparam logic [3:0] OpLoad  = 4'h5;
    localparam logic [3:0] OpStore = 4'h6;
    localparam logic [3:0] OpJump  = 4'h7;
    localparam logic [3:0] OpBeq   = 4'h8;
    localparam logic [3:0] OpHalt  = 4'hF;

    localparam int unsigned OpLsb  = 12;
    localparam int unsigned RdLsb  = 10;
    localparam int unsigned Rs1Lsb = 8;
    localparam int unsigned Rs2Lsb = 6;
    localparam int unsigned ImmLsb = 0;
    localparam int unsigned ImmW   = 8;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StHalt
    } state_e;

endpackage

// File: rtl/risc_core_mc_if.sv
// Instruction memory, data memory and I/O signals of the core; the core is the
// master, memories and the I/O environment sit on the slave side.
interface risc_core_mc_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 8
);
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] io_in;
    logic [DATA_W-1:0] io_out;
    logic              io_out_valid;
    logic              halted;
    logic              illegal_op;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ack,
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack,
        input  io_in,
        output io_out, io_out_valid, halted, illegal_op
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ack,
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack,
        output io_in,
        input  io_out, io_out_valid, halted, illegal_op
    );

endinterface

// File: rtl/risc_core_regfile.sv
// Four-entry register file: three combinational read ports, one synchronous
// write port, R0 reads as zero and ignores writes.
module risc_core_regfile #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        rs1_addr,
    input  logic [1:0]        rs2_addr,
    input  logic [1:0]        rd_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic [DATA_W-1:0] rd_data,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs_q [4];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != 2'd0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == 2'd0) ? '0 : regs_q[rs1_addr];
    assign rs2_data = (rs2_addr == 2'd0) ? '0 : regs_q[rs2_addr];
    assign rd_data  = (rd_addr == 2'd0) ? '0 : regs_q[rd_addr];

endmodule

// File: rtl/risc_core_mc.sv
// Multi-cycle RISC core: fetch/decode/execute/memory FSM with req/ack memory
// handshakes, one memory-mapped I/O address and a sticky illegal-opcode flag.
module risc_core_mc
    import risc_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       PC_W     = 8,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [DATA_W-1:0] IO_ADDR  = DATA_W'(8'hFF)
) (
    input logic            clk,
    input logic            reset,
    risc_core_mc_if.master bus
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, op_r_q, op_r_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic              io_valid_q, io_valid_d;
    logic              illegal_q, illegal_d;

    logic [3:0]        opcode;
    logic [1:0]        rd, rs1, rs2;
    logic [DATA_W-1:0] imm_data, eff_addr, rs1_val, rs2_val, rd_val;
    logic [PC_W-1:0]   imm_pc, pc_inc;
    logic              rf_we;
    logic [DATA_W-1:0] rf_wdata;
    logic              imem_req, dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata;

    assign opcode   = instr_q[OpLsb +: 4];
    assign rd       = instr_q[RdLsb +: 2];
    assign rs1      = instr_q[Rs1Lsb +: 2];
    assign rs2      = instr_q[Rs2Lsb +: 2];
    assign imm_data = DATA_W'(instr_q[ImmLsb +: ImmW]);
    assign imm_pc   = PC_W'(instr_q[ImmLsb +: ImmW]);
    assign pc_inc   = pc_q + PC_W'(1);
    assign eff_addr = op_a_q + imm_data;

    risc_core_regfile #(
        .DATA_W(DATA_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs1_addr(rs1),
        .rs2_addr(rs2),
        .rd_addr (rd),
        .rs1_data(rs1_val),
        .rs2_data(rs2_val),
        .rd_data (rd_val),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (rf_wdata)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_r_d     = op_r_q;
        io_out_d   = io_out_q;
        io_valid_d = 1'b0;
        illegal_d  = illegal_q;
        rf_we      = 1'b0;
        rf_wdata   = '0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_wdata = '0;

        unique case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                if (bus.imem_ack) begin
                    instr_d = bus.imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                op_a_d  = rs1_val;
                op_b_d  = rs2_val;
                op_r_d  = rd_val;
                state_d = StExec;
            end
            StExec: begin
                pc_d    = pc_inc;
                state_d = StFetch;
                case (opcode)
                    OpAdd: begin rf_we = 1'b1; rf_wdata = op_a_q + op_b_q; end
                    OpSub: begin rf_we = 1'b1; rf_wdata = op_a_q - op_b_q; end
                    OpAnd: begin rf_we = 1'b1; rf_wdata = op_a_q & op_b_q; end
                    OpOr:  begin rf_we = 1'b1; rf_wdata = op_a_q | op_b_q; end
                    OpLi:  begin rf_we = 1'b1; rf_wdata = imm_data; end
                    // PC advances only once the memory phase completes
                    OpLoad, OpStore: begin
                        pc_d    = pc_q;
                        state_d = StMem;
                    end
                    OpJump: pc_d = imm_pc;
                    OpBeq:  pc_d = (op_r_q == op_a_q) ? imm_pc : pc_inc;
                    OpHalt: begin
                        pc_d    = pc_q;
                        state_d = StHalt;
                    end
                    default: illegal_d = 1'b1;
                endcase
            end
            StMem: begin
                if (eff_addr == IO_ADDR) begin
                    if (opcode == OpLoad) begin
                        rf_we    = 1'b1;
                        rf_wdata = bus.io_in;
                    end else begin
                        io_out_d   = op_r_q;
                        io_valid_d = 1'b1;
                    end
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end else begin
                    dmem_req   = 1'b1;
                    dmem_we    = (opcode == OpStore);
                    dmem_addr  = eff_addr;
                    dmem_wdata = (opcode == OpStore) ? op_r_q : '0;
                    if (bus.dmem_ack) begin
                        if (opcode == OpLoad) begin
                            rf_we    = 1'b1;
                            rf_wdata = bus.dmem_rdata;
                        end
                        pc_d    = pc_inc;
                        state_d = StFetch;
                    end
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_r_q     <= '0;
            io_out_q   <= '0;
            io_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_r_q     <= op_r_d;
            io_out_q   <= io_out_d;
            io_valid_q <= io_valid_d;
            illegal_q  <= illegal_d;
        end
    end

    // Requests are gated by reset so an in-flight access is abandoned at once
    assign bus.imem_req     = imem_req & ~reset;
    assign bus.imem_addr    = pc_q;
    assign bus.dmem_req     = dmem_req & ~reset;
    assign bus.dmem_we      = dmem_we & ~reset;
    assign bus.dmem_addr    = dmem_addr;
    assign bus.dmem_wdata   = dmem_wdata;
    assign bus.io_out       = io_out_q;
    assign bus.io_out_valid = io_valid_q;
    assign bus.halted       = (state_q == StHalt);
    assign bus.illegal_op   = illegal_q;

endmodule

// File: tb/tb_risc_core_mc.sv
// Cycle-accurate bench: acts as instruction/data memory and I/O, runs each
// instruction against an architectural model and checks every bus cycle.
module tb_risc_core_mc;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    logic [7:0] m_pc;
    logic [7:0] m_regs [4];
    logic [7:0] m_dmem [256];
    logic [7:0] m_io_out;
    logic       m_illegal;
    logic       io_pulse;

    risc_core_mc_if #(.DATA_W(8), .PC_W(8)) bus ();

    risc_core_mc #(
        .DATA_W  (8),
        .PC_W    (8),
        .RESET_PC(8'h00),
        .IO_ADDR (8'hFF)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic step_neg();
        @(negedge clk);
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] r, input logic [7:0] v);
        if (r != 2'd0) m_regs[r] = v;
    endtask

    task automatic model_reset();
        m_pc = 8'h00;
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_io_out  = 8'h00;
        m_illegal = 1'b0;
        io_pulse  = 1'b0;
    endtask

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs1, input logic [7:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic exec_instr(input logic [15:0] ins, input int fw, input int mw);
        logic [3:0] op;
        logic [1:0] rd, rs1, rs2;
        logic [7:0] imm, a, b, d, ea, v;
        op  = ins[15:12];
        rd  = ins[11:10];
        rs1 = ins[9:8];
        rs2 = ins[7:6];
        imm = ins[7:0];
        a   = m_regs[rs1];
        b   = m_regs[rs2];
        d   = m_regs[rd];
        ea  = a + imm;

        for (int k = 0; k <= fw; k++) begin
            step_neg();
            check_eq("fetch_req", 32'(bus.imem_req), 32'(1));
            check_eq("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
            check_eq("fetch_dmem_idle", 32'(bus.dmem_req), 32'(0));
            check_eq("io_valid", 32'(bus.io_out_valid), 32'((k == 0) && io_pulse));
            if (k == 0) check_eq("io_out", 32'(bus.io_out), 32'(m_io_out));
            if (k == fw) begin
                bus.imem_ack   = 1'b1;
                bus.imem_rdata = ins;
            end
            @(posedge clk);
        end
        io_pulse = 1'b0;

        step_neg();
        check_eq("dec_idle", 32'({bus.imem_req, bus.dmem_req}), 32'(0));
        check_eq("illegal_op", 32'(bus.illegal_op), 32'(m_illegal));
        @(posedge clk);
        step_neg();
        check_eq("exe_idle", 32'({bus.imem_req, bus.dmem_req}), 32'(0));
        check_eq("halted_low", 32'(bus.halted), 32'(0));
        @(posedge clk);

        case (op)
            4'h0: begin wr_reg(rd, a + b); m_pc = m_pc + 8'd1; end
            4'h1: begin wr_reg(rd, a - b); m_pc = m_pc + 8'd1; end
            4'h2: begin wr_reg(rd, a & b); m_pc = m_pc + 8'd1; end
            4'h3: begin wr_reg(rd, a | b); m_pc = m_pc + 8'd1; end
            4'h4: begin wr_reg(rd, imm); m_pc = m_pc + 8'd1; end
            4'h5, 4'h6: begin
                if (ea == 8'hFF) begin
                    step_neg();
                    check_eq("io_no_dreq", 32'(bus.dmem_req), 32'(0));
                    v = 8'($urandom);
                    bus.io_in = v;
                    @(posedge clk);
                    if (op == 4'h5) wr_reg(rd, v);
                    else begin
                        m_io_out = d;
                        io_pulse = 1'b1;
                    end
                end else begin
                    for (int k = 0; k <= mw; k++) begin
                        step_neg();
                        check_eq("dmem_req", 32'(bus.dmem_req), 32'(1));
                        check_eq("dmem_we", 32'(bus.dmem_we), 32'(op == 4'h6));
                        check_eq("dmem_addr", 32'(bus.dmem_addr), 32'(ea));
                        check_eq("dmem_io_excl", 32'(bus.io_out_valid), 32'(0));
                        if (op == 4'h6) check_eq("dmem_wdata", 32'(bus.dmem_wdata), 32'(d));
                        if (k == mw) begin
                            bus.dmem_ack   = 1'b1;
                            bus.dmem_rdata = m_dmem[ea];
                        end
                        @(posedge clk);
                    end
                    if (op == 4'h6) m_dmem[ea] = d;
                    else wr_reg(rd, m_dmem[ea]);
                end
                m_pc = m_pc + 8'd1;
            end
            4'h7: m_pc = imm;
            4'h8: m_pc = (d == a) ? imm : m_pc + 8'd1;
            4'hF: begin
                for (int k = 0; k < 4; k++) begin
                    step_neg();
                    check_eq("halted", 32'(bus.halted), 32'(1));
                    check_eq("halt_no_fetch", 32'(bus.imem_req), 32'(0));
                    check_eq("halt_pc", 32'(bus.imem_addr), 32'(m_pc));
                end
            end
            default: begin m_illegal = 1'b1; m_pc = m_pc + 8'd1; end
        endcase
    endtask

    initial begin
        logic [15:0] ins;
        logic [3:0]  op;
        n_checks       = 0;
        n_pass         = 0;
        reset          = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 16'h0000;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 8'h00;
        bus.io_in      = 8'h00;
        for (int i = 0; i < 256; i++) m_dmem[i] = 8'($urandom);
        model_reset();

        repeat (2) @(negedge clk);
        check_eq("rst_imem_req", 32'(bus.imem_req), 32'(0));
        check_eq("rst_imem_addr", 32'(bus.imem_addr), 32'(0));
        check_eq("rst_dmem_req", 32'(bus.dmem_req), 32'(0));
        check_eq("rst_dmem_we", 32'(bus.dmem_we), 32'(0));
        check_eq("rst_io_out", 32'(bus.io_out), 32'(0));
        check_eq("rst_io_valid", 32'(bus.io_out_valid), 32'(0));
        check_eq("rst_halted", 32'(bus.halted), 32'(0));
        check_eq("rst_illegal", 32'(bus.illegal_op), 32'(0));
        reset = 1'b0;

        // Reset while a fetch is pending: request must drop without a clock edge
        exec_instr(enc(4'h4, 2'd1, 2'd0, 8'h11), 0, 0);
        step_neg();
        check_eq("midfetch_req", 32'(bus.imem_req), 32'(1));
        reset = 1'b1;
        #1;
        check_eq("midfetch_drop", 32'(bus.imem_req), 32'(0));
        check_eq("midfetch_pc", 32'(bus.imem_addr), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        exec_instr(enc(4'h6, 2'd1, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'h4, 2'd1, 2'd0, 8'hA5), 0, 0);
        exec_instr(enc(4'h4, 2'd2, 2'd0, 8'h5A), 0, 0);
        exec_instr(enc(4'h0, 2'd3, 2'd1, {2'd2, 6'd0}), 0, 0);
        exec_instr(enc(4'h6, 2'd3, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'h1, 2'd3, 2'd2, {2'd1, 6'd0}), 0, 0);
        exec_instr(enc(4'h6, 2'd3, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'h6, 2'd1, 2'd0, 8'h20), 0, 2);
        exec_instr(enc(4'h5, 2'd3, 2'd0, 8'h20), 0, 0);
        exec_instr(enc(4'h6, 2'd3, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'h5, 2'd2, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'h6, 2'd2, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'h6, 2'd1, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'h8, 2'd1, 2'd1, 8'h10), 0, 0);
        exec_instr(enc(4'h8, 2'd1, 2'd0, 8'h30), 0, 0);
        exec_instr(enc(4'h7, 2'd0, 2'd0, 8'h05), 0, 0);
        exec_instr(enc(4'h4, 2'd0, 2'd0, 8'h77), 0, 0);
        exec_instr(enc(4'h6, 2'd0, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'hB, 2'd1, 2'd2, 8'h00), 0, 0);

        for (int n = 0; n < 200; n++) begin
            op  = 4'($urandom_range(0, 14));
            ins = {op, 2'($urandom), 2'($urandom), 8'($urandom)};
            if ((op == 4'h5 || op == 4'h6) && $urandom_range(0, 3) == 0) ins[9:0] = 10'h0FF;
            exec_instr(ins, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        exec_instr(enc(4'hF, 2'd0, 2'd0, 8'h00), 0, 0);
        reset = 1'b1;
        #1;
        check_eq("post_halt_rst_halted", 32'(bus.halted), 32'(0));
        check_eq("post_halt_rst_pc", 32'(bus.imem_addr), 32'(0));
        check_eq("post_halt_rst_illegal", 32'(bus.illegal_op), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        exec_instr(enc(4'h4, 2'd2, 2'd0, 8'h3C), 1, 0);
        exec_instr(enc(4'h6, 2'd2, 2'd0, 8'hFF), 0, 0);
        exec_instr(enc(4'h0, 2'd0, 2'd0, 8'h00), 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
